// File: rtl/psram_arbiter_pkg.sv
// psram_arbiter shared types and constants.
// FSM states, latched request bundle, sel encodings.
package psram_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LO,
    GAP,
    HI,
    DONE
  } state_t;

  localparam int NUM_MASTERS = 2;

  localparam logic [3:0] SEL_B1 = 4'b0001;
  localparam logic [3:0] SEL_B2 = 4'b0011;
  localparam logic [3:0] SEL_B3 = 4'b0111;
  localparam logic [3:0] SEL_B4 = 4'b1111;

  typedef struct packed {
    logic [20:0] addr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] data;
  } req_t;

  function automatic logic [15:0] mask_half(
    input logic [15:0] d,
    input logic [1:0]  be
  );
    return {be[1] ? d[15:8] : 8'h00,
            be[0] ? d[7:0]  : 8'h00};
  endfunction

endpackage

// File: rtl/psram_arbiter_rr_grant2.sv
// 2-way round-robin picker.
// Tie goes to the port not granted last time.
import psram_arbiter_pkg::*;

module rr_grant2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt,
  output logic       any
);

  logic last_q;

  assign any = |req;

  // choose a winner from the current requests
  always_comb begin
    gnt = 1'b0;
    unique case (req)
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last_q;
      default: gnt = 1'b0;
    endcase
  end

  // remember who won when the grant is taken
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (take) begin
      last_q <= gnt;
    end
  end

endmodule

// File: rtl/psram_arbiter.sv
// Two-port Wishbone arbiter in front of psram.
// Splits each 32-bit access into 16-bit halves.
import psram_arbiter_pkg::*;

module psram_arbiter #(
  parameter int CLK_PERIOD_NS = 20
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [22:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  output logic        m0_ack_o,
  output logic [31:0] m0_data_o,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [22:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  output logic        m1_ack_o,
  output logic [31:0] m1_data_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  output logic        s_we_o,
  output logic [1:0]  s_sel_o,
  output logic [21:0] s_addr_o,
  output logic [15:0] s_data_o,
  input  logic        s_ack_i,
  input  logic [15:0] s_data_i
);

  state_t state, nxt;
  req_t   r_q;
  logic   g_q;
  logic   gnt, any, take, stb_g, hi;
  logic [1:0] req;
  logic [1:0] done_q;
  logic [NUM_MASTERS-1:0][31:0] rd_q;

  assign req   = {m1_stb_i & m1_cyc_i,
                  m0_stb_i & m0_cyc_i};
  assign take  = (state == IDLE) & any;
  assign stb_g = g_q ? m1_stb_i : m0_stb_i;
  assign hi    = (state == HI);

  rr_grant2 u_rr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req   (req),
    .take  (take),
    .gnt   (gnt),
    .any   (any)
  );

  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // next state and slave-side outputs
  always_comb begin
    nxt      = state;
    s_stb_o  = 1'b0;
    s_cyc_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = 2'b00;
    s_addr_o = '0;
    s_data_o = '0;
    unique case (state)
      IDLE: if (any) nxt = LO;
      LO: begin
        if (s_ack_i) begin
          nxt = (r_q.sel[3:2] != 2'b00) ? GAP : DONE;
        end
      end
      GAP:  nxt = HI;
      HI:   if (s_ack_i) nxt = DONE;
      DONE: if (!stb_g) nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (state == LO || state == HI) begin
      s_stb_o  = 1'b1;
      s_cyc_o  = 1'b1;
      s_we_o   = r_q.we;
      s_sel_o  = hi ? r_q.sel[3:2] : r_q.sel[1:0];
      s_addr_o = {r_q.addr, hi};
      s_data_o = hi ? r_q.data[31:16] : r_q.data[15:0];
    end
  end

  // latch request on grant, collect read halves, register done
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_q    <= '0;
      g_q    <= 1'b0;
      rd_q   <= '0;
      done_q <= '0;
    end else begin
      done_q <= '0;
      if (state == DONE && stb_g) begin
        done_q[g_q] <= 1'b1;
      end
      if (take) begin
        g_q <= gnt;
        r_q <= gnt
          ? {m1_addr_i[22:2], m1_sel_i, m1_we_i, m1_data_i}
          : {m0_addr_i[22:2], m0_sel_i, m0_we_i, m0_data_i};
        rd_q[gnt] <= '0;
      end
      if (s_ack_i && state == LO) begin
        rd_q[g_q][15:0] <= mask_half(s_data_i, r_q.sel[1:0]);
      end
      if (s_ack_i && state == HI) begin
        rd_q[g_q][31:16] <= mask_half(s_data_i, r_q.sel[3:2]);
      end
    end
  end

  assign m0_ack_o  = done_q[0] & m0_stb_i;
  assign m1_ack_o  = done_q[1] & m1_stb_i;
  assign m0_data_o = rd_q[0];
  assign m1_data_o = rd_q[1];

  a_period: assert property (@(posedge clk_i) CLK_PERIOD_NS > 0);
  a_gap: assert property (@(posedge clk_i) disable iff (rst_i)
    (state == GAP) |-> !s_stb_o);
  a_one_ack: assert property (@(posedge clk_i)
    !(m0_ack_o && m1_ack_o));

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter.
// Small psram model acks 4 cycles after sampling stb.
module tb_psram_arbiter;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst;
  logic        m0_stb, m0_cyc, m0_we, m0_ack;
  logic [3:0]  m0_sel;
  logic [22:0] m0_addr;
  logic [31:0] m0_wd, m0_rd;
  logic        m1_stb, m1_cyc, m1_we, m1_ack;
  logic [3:0]  m1_sel;
  logic [22:0] m1_addr;
  logic [31:0] m1_wd, m1_rd;
  logic        s_stb, s_cyc, s_we;
  logic        s_ack = 1'b0;
  logic [1:0]  s_sel;
  logic [21:0] s_addr;
  logic [15:0] s_wd;
  logic [15:0] s_rd = 16'h0;

  psram_arbiter #(.CLK_PERIOD_NS(20)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .m0_stb_i  (m0_stb),
    .m0_cyc_i  (m0_cyc),
    .m0_we_i   (m0_we),
    .m0_sel_i  (m0_sel),
    .m0_addr_i (m0_addr),
    .m0_data_i (m0_wd),
    .m0_ack_o  (m0_ack),
    .m0_data_o (m0_rd),
    .m1_stb_i  (m1_stb),
    .m1_cyc_i  (m1_cyc),
    .m1_we_i   (m1_we),
    .m1_sel_i  (m1_sel),
    .m1_addr_i (m1_addr),
    .m1_data_i (m1_wd),
    .m1_ack_o  (m1_ack),
    .m1_data_o (m1_rd),
    .s_stb_o   (s_stb),
    .s_cyc_o   (s_cyc),
    .s_we_o    (s_we),
    .s_sel_o   (s_sel),
    .s_addr_o  (s_addr),
    .s_data_o  (s_wd),
    .s_ack_i   (s_ack),
    .s_data_i  (s_rd)
  );

  // psram model, transaction log and ack monitor
  logic [15:0] mem [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_a;
  logic [15:0] pl_d;
  int          cnt = 0;
  int          txn_n = 0;
  int          ack0_cnt = 0;
  logic [7:0]  p_a;
  logic [1:0]  p_sel;
  logic        p_we;
  logic [15:0] p_d;
  logic [21:0] t_a   [0:63];
  logic [1:0]  t_sel [0:63];
  logic        t_we  [0:63];
  logic [15:0] t_d   [0:63];

  always @(posedge clk) begin
    if (pl_en) mem[pl_a] = pl_d;
    if (rst) begin
      cnt   <= 0;
      s_ack <= 1'b0;
    end else if (s_ack) begin
      s_ack <= 1'b0;
    end else if (cnt == 1) begin
      cnt   <= 0;
      s_ack <= 1'b1;
      if (p_we) begin
        if (p_sel[0]) mem[p_a][7:0]  = p_d[7:0];
        if (p_sel[1]) mem[p_a][15:8] = p_d[15:8];
      end else begin
        s_rd <= mem[p_a];
      end
    end else if (cnt > 1) begin
      cnt <= cnt - 1;
    end else if (s_stb && s_cyc) begin
      cnt   <= 3;
      p_a   <= s_addr[7:0];
      p_sel <= s_sel;
      p_we  <= s_we;
      p_d   <= s_wd;
      t_a[txn_n & 63]   <= s_addr;
      t_sel[txn_n & 63] <= s_sel;
      t_we[txn_n & 63]  <= s_we;
      t_d[txn_n & 63]   <= s_wd;
      txn_n <= txn_n + 1;
    end
    if (m0_ack) ack0_cnt <= ack0_cnt + 1;
  end

  int   n_cmp = 0;
  int   n_bad = 0;
  logic st [0:63];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    pl_en = 1'b1;
    pl_a  = a;
    pl_d  = d;
    step();
    pl_en = 1'b0;
  endtask

  task automatic set_req(input int p, input logic we, input logic [3:0] sel,
                         input logic [22:0] a, input logic [31:0] d);
    if (p == 0) begin
      m0_stb = 1; m0_cyc = 1; m0_we = we; m0_sel = sel;
      m0_addr = a; m0_wd = d;
    end else begin
      m1_stb = 1; m1_cyc = 1; m1_we = we; m1_sel = sel;
      m1_addr = a; m1_wd = d;
    end
  endtask

  task automatic drop(input int p);
    if (p == 0) begin
      m0_stb = 0; m0_cyc = 0;
    end else begin
      m1_stb = 0; m1_cyc = 0;
    end
  endtask

  // n counts edges seen; ack after edge E gives n == E+1
  task automatic wait_ack(input int p, input int exp_n, input string tag);
    int   n;
    logic hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < 40) begin
      step();
      st[n] = s_stb;
      n++;
      hit = (p == 0) ? m0_ack : m1_ack;
    end
    check(tag, hit ? n : 0, exp_n);
  endtask

  task automatic finish_req(input int p);
    drop(p);
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  int b_txn, b_ack;

  initial begin
    rst = 1'b1;
    drop(0);
    drop(1);
    m0_we = 0; m0_sel = 0; m0_addr = 0; m0_wd = 0;
    m1_we = 0; m1_sel = 0; m1_addr = 0; m1_wd = 0;
    for (int i = 0; i < 256; i++) preload(8'(i), 16'h0);
    preload(8'h80, 16'h1234);
    preload(8'h81, 16'hABCD);
    preload(8'h10, 16'h1111);
    preload(8'h12, 16'h22EE);
    preload(8'h09, 16'hAA00);
    preload(8'h30, 16'h5A5A);
    do_reset();

    check("rst_s_stb", s_stb, 0);
    check("rst_s_cyc", s_cyc, 0);
    check("rst_s_we", s_we, 0);
    check("rst_s_sel", s_sel, 0);
    check("rst_s_addr", s_addr, 0);
    check("rst_s_data", s_wd, 0);
    check("rst_acks", {m0_ack, m1_ack}, 0);
    check("rst_m0_data", m0_rd, 0);
    check("rst_m1_data", m1_rd, 0);

    // 32-bit read on port 0
    b_txn = txn_n;
    set_req(0, 0, 4'b1111, 23'h000100, 32'h0);
    wait_ack(0, 13, "rd32_lat");
    check("rd32_data", m0_rd, 32'hABCD1234);
    check("rd32_ntxn", txn_n - b_txn, 2);
    check("rd32_a0", t_a[b_txn], 22'h80);
    check("rd32_a1", t_a[b_txn + 1], 22'h81);
    check("rd32_stb_e0", st[0], 1);
    check("rd32_gap_e5", st[5], 0);
    check("rd32_hi_e6", st[6], 1);
    finish_req(0);

    // 16-bit write on port 1
    b_txn = txn_n;
    b_ack = ack0_cnt;
    set_req(1, 1, 4'b0011, 23'h000008, 32'hDEADBEEF);
    wait_ack(1, 7, "wr16_lat");
    check("wr16_ntxn", txn_n - b_txn, 1);
    check("wr16_addr", t_a[b_txn], 22'h4);
    check("wr16_sel", t_sel[b_txn], 2'b11);
    check("wr16_data", t_d[b_txn], 16'hBEEF);
    check("wr16_we", t_we[b_txn], 1);
    check("wr16_no_m0", ack0_cnt - b_ack, 0);
    finish_req(1);

    // simultaneous requests after reset
    do_reset();
    set_req(0, 0, 4'b0011, 23'h000020, 32'h0);
    set_req(1, 0, 4'b0001, 23'h000024, 32'h0);
    wait_ack(0, 7, "tie1_p0_lat");
    check("tie1_p1_idle", m1_ack, 0);
    check("tie1_p0_data", m0_rd, 32'h00001111);
    drop(0);
    step();
    set_req(0, 0, 4'b0011, 23'h000020, 32'h0);
    wait_ack(1, 7, "tie2_p1_lat");
    check("tie2_p0_idle", m0_ack, 0);
    check("tie2_p1_data", m1_rd, 32'h000000EE);
    finish_req(1);
    wait_ack(0, 7, "tie2_p0_lat");
    finish_req(0);

    // port 0 abandons a 32-bit read during LO
    b_txn = txn_n;
    b_ack = ack0_cnt;
    set_req(0, 0, 4'b1111, 23'h000100, 32'h0);
    step();
    step();
    drop(0);
    set_req(1, 0, 4'b0001, 23'h000020, 32'h0);
    wait_ack(1, 18, "abort_p1_lat");
    check("abort_ntxn", txn_n - b_txn, 3);
    check("abort_a0", t_a[b_txn], 22'h80);
    check("abort_a1", t_a[b_txn + 1], 22'h81);
    check("abort_a2", t_a[b_txn + 2], 22'h10);
    check("abort_no_m0", ack0_cnt - b_ack, 0);
    check("abort_p1_data", m1_rd, 32'h00000011);
    finish_req(1);

    // reset during HI
    set_req(0, 0, 4'b1111, 23'h000100, 32'h0);
    repeat (8) step();
    check("hi_stb_pre", s_stb, 1);
    rst = 1'b1;
    step();
    check("hirst_s_stb", s_stb, 0);
    check("hirst_s_cyc", s_cyc, 0);
    check("hirst_s_addr", s_addr, 0);
    check("hirst_s_sel", s_sel, 0);
    check("hirst_s_data", s_wd, 0);
    check("hirst_acks", {m0_ack, m1_ack}, 0);
    check("hirst_m0_data", m0_rd, 0);
    check("hirst_m1_data", m1_rd, 0);
    rst = 1'b0;
    drop(0);
    set_req(1, 0, 4'b0011, 23'h000060, 32'h0);
    wait_ack(1, 7, "post_rst_lat");
    check("post_rst_data", m1_rd, 32'h00005A5A);
    finish_req(1);

    // 24-bit write then read back
    b_txn = txn_n;
    set_req(1, 1, 4'b0111, 23'h000010, 32'h55667788);
    wait_ack(1, 13, "wr24_lat");
    check("wr24_gap_e5", st[5], 0);
    check("wr24_hi_e6", st[6], 1);
    check("wr24_hi_sel", t_sel[b_txn + 1], 2'b01);
    check("wr24_hi_data", t_d[b_txn + 1], 16'h5566);
    finish_req(1);
    set_req(0, 0, 4'b1111, 23'h000010, 32'h0);
    wait_ack(0, 13, "rb32_lat");
    check("rb32_data", m0_rd, 32'hAA667788);
    finish_req(0);
    set_req(0, 0, 4'b0111, 23'h000010, 32'h0);
    wait_ack(0, 13, "rb24_lat");
    check("rb24_data", m0_rd, 32'h00667788);
    finish_req(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/psram_arbiter.md
# psram_arbiter

Two-port Wishbone arbiter and width adapter in front of the 16-bit `psram` controller. It shares the single PSRAM between an instruction-fetch master (port 0) and a data master (port 1) using round-robin arbitration. Each 32-bit master access is split into one or two sequential 16-bit PSRAM transactions. It sits between the CPU memory interfaces and the `psram` instance.

## Interface
Parameters:
- `CLK_PERIOD_NS`, default 20: clock period; used only for documentation and assertions, and forwarded unchanged to `psram`.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk_i`  in  1  clock
- `rst_i`  in  1  synchronous reset, active high
- `m0_stb_i`, `m1_stb_i`  in  1  request strobe
- `m0_cyc_i`, `m1_cyc_i`  in  1  cycle valid
- `m0_we_i`, `m1_we_i`  in  1  1 = write, 0 = read
- `m0_sel_i`, `m1_sel_i`  in  4  byte count: 0001, 0011, 0111 or 1111
- `m0_addr_i`, `m1_addr_i`  in  23  byte address; bits [1:0] are ignored (word aligned)
- `m0_data_i`, `m1_data_i`  in  32  write data
- `m0_ack_o`, `m1_ack_o`  out  1  completion
- `m0_data_o`, `m1_data_o`  out  32  read data
- `s_stb_o`, `s_cyc_o`, `s_we_o`  out  1  to `psram`
- `s_sel_o`  out  2  byte enables for the current halfword
- `s_addr_o`  out  22  halfword address
- `s_data_o`  out  16  halfword write data
- `s_ack_i`  in  1  from `psram`
- `s_data_i`  in  16  from `psram`

## Operation
State machine:
- `IDLE` → `LO` on grant.
- `LO` → `GAP` on `s_ack_i`, if the upper halfword is needed (`sel[3:2]` != 0).
- `LO` → `DONE` on `s_ack_i` otherwise.
- `GAP` → `HI` after 1 cycle.
- `HI` → `DONE` on `s_ack_i`.
- `DONE` → `IDLE` when the granted master's `stb_i` is low.

Arbitration, in `IDLE`:
- A master requests when `stb_i & cyc_i`.
- If one master requests, it is granted.
- If both request, the master not granted last time wins. `last_grant` resets to 1, so port 0 wins the first tie.
- On grant, `addr`, `sel`, `we` and `data` are latched. Master inputs are ignored until the next `IDLE`.

Halfword mapping:
- LO phase: `s_addr_o = {addr[22:2],0}`, `s_sel_o = sel[1:0]`, `s_data_o = data[15:0]`.
- HI phase: `s_addr_o = {addr[22:2],1}`, `s_sel_o = sel[3:2]`, `s_data_o = data[31:16]`.

Read data:
- On each `s_ack_i`, `s_data_i` is stored into the matching half of the granted `mN_data_o`.
- Bytes not covered by `sel` return 0.

Handshakes:
- `s_stb_o` and `s_cyc_o` drop in the cycle after `s_ack_i` is sampled.
- `GAP` guarantees at least 1 low cycle of `s_stb_o`, so `psram` can clear its ack.
- `mN_ack_o` = registered `done[N]` & `mN_stb_i`. It is held until the master drops `stb_i` and is never asserted for the non-granted port.
- If the granted master drops `stb_i` mid-transaction, the PSRAM transaction still completes (no abort). No ack is produced and the FSM returns to `IDLE` from `DONE`.
- A `s_ack_i` outside `LO`/`HI` is ignored.

## Timing
Reset values (applied one cycle after `rst_i` is sampled high, including mid-transaction):
- All `s_*` outputs 0, `mN_ack_o` 0, `mN_data_o` 0, state `IDLE`, `last_grant` 1.
- `psram` shares `rst_i`, so no transaction survives reset.

Latency with `CLK_PERIOD_NS` = 20 (`psram` acks 4 cycles after sampling `stb`); edge 0 is the edge where the request is sampled in `IDLE`:
- `s_stb_o` is high after edge 0.
- The first `s_ack_i` is sampled at edge 5.
- 16-bit or smaller access: `mN_ack_o` is visible after edge 6.
- 32-bit or 24-bit access: `GAP` after edge 5, HI `s_stb_o` after edge 6, second ack at edge 11, `mN_ack_o` after edge 12.
- A new grant is possible at the edge after the master drops `stb_i`.

## Structure
- `psram_arbiter_pkg` holds:
  - the `state_t` enum (`IDLE`, `LO`, `GAP`, `HI`, `DONE`)
  - `NUM_MASTERS` = 2
  - the `sel` encoding constants `SEL_B1`, `SEL_B2`, `SEL_B3`, `SEL_B4`
- One sub-module, `rr_grant2`: combinational 2-way round-robin picker with a registered `last_grant`.
- The width split and FSM stay in `psram_arbiter`.

## Test plan
- Port 0 reads word at 0x000100, `sel` 1111; PSRAM holds 0x1234 at halfword 0x80 and 0xABCD at 0x81 → two slave transactions to 0x80 then 0x81, `m0_data_o` = 0xABCD1234, ack after edge 12.
- Port 1 writes 0xDEADBEEF to 0x000008, `sel` 0011 → exactly one slave write: `s_addr_o` 0x4, `s_sel_o` 11, `s_data_o` 0xBEEF; ack after edge 6.
- Both ports request a read in the same cycle after reset → port 0 is served first, then port 1. A second simultaneous request → port 1 is served first.
- Port 0 drops `stb_i` during `LO` of a 32-bit read → both halfwords still complete, `m0_ack_o` stays 0, FSM returns to `IDLE`, and port 1 is granted next.
- `rst_i` asserted during `HI` → all outputs 0 on the next cycle; a following port 1 read completes normally.
- Port 1 issues a `sel` 0111 write, then port 0 reads it back → byte 3 is unchanged and `s_stb_o` has 1 low cycle between phases.
